// File: rtl/stepper_seq_ctrl_pkg.sv
// Shared definitions for the stepper sequencer: mode codes, FSM states,
// the half-step coil table and the index helper functions.
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Half-step sequence; even entries are single-coil, odd entries two-coil.
  localparam logic [3:0] HALF_TABLE [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return HALF_TABLE[idx];
  endfunction

  // Reserved mode 3 falls in with half-step, so bit 1 alone decides.
  function automatic logic mode_is_half(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Snap the index onto the sub-sequence the mode walks through:
  // wave uses even entries, full uses odd entries, half uses all.
  function automatic logic [2:0] align_idx(input logic [2:0] idx,
                                           input logic [1:0] mode);
    logic [2:0] res;
    res = idx;
    if (mode == MODE_WAVE)      res = {idx[2:1], 1'b0};
    else if (mode == MODE_FULL) res = {idx[2:1], 1'b1};
    return res;
  endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// Move-command channel between the motion logic and the stepper sequencer.
//
// Handshake: a command transfers on a rising new_clk edge where cmd_valid
// and cmd_ready are both high. The master holds cmd_dir, cmd_steps,
// cmd_mode and period stable while cmd_valid is high and not yet accepted;
// cmd_ready may drop without a transfer (busy, abort, reset) and the master
// simply keeps offering.
interface stepper_seq_ctrl_if #(
  parameter int STEP_W = 16,
  parameter int PER_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [1:0]        cmd_mode;
  logic [PER_W-1:0]  period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_mode, period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_mode, period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq_ctrl_tick_gen.sv
// Step-rate divider: counts 0..period-1 while enabled and flags the last
// count so the sequencer can fire one step per period.
module stepper_tick_gen #(
  parameter int PER_W = 16
) (
  input  logic             new_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] count;

  // period is never 0 here; the sequencer latches max(period,1).
  assign tick = en && (count == period - PER_W'(1));

  // Free-running count while enabled, restarted on every command accept.
  always_ff @(posedge new_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PER_W'(1);
    end
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// 4-phase stepper sequencer: accepts move commands of N steps in wave,
// full or half-step mode, paces them at a programmable period, keeps a
// signed position count and supports abort and idle holding torque.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int POS_W  = 24,
  parameter int PER_W  = 16
) (
  input  logic                    new_clk,
  input  logic                    rst,
  stepper_seq_ctrl_if.slave       cmd,
  input  logic                    hold_en,
  input  logic                    abort,
  output logic [3:0]              phase,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position,
  output state_t                  dbg_state
);

  state_t            state;
  logic [2:0]        idx;
  logic              dir_r;
  logic              half_r;
  logic [PER_W-1:0]  period_r;
  logic [STEP_W-1:0] remaining;

  logic              accept;
  logic              tick;
  logic [2:0]        cmd_idx;
  logic [2:0]        step_idx;
  logic [2:0]        stride;

  assign dbg_state = state;

  // Ready only in IDLE, never while abort is asserted or reset is held.
  assign cmd.cmd_ready = (state == ST_IDLE) && !abort && !rst;
  assign accept        = (state == ST_IDLE) && cmd.cmd_valid && !abort;

  // Index the move starts from, snapped to the commanded mode.
  assign cmd_idx  = align_idx(idx, cmd.cmd_mode);

  // Half-step walks every entry, wave/full skip every other one.
  assign stride   = half_r ? 3'd1 : 3'd2;
  assign step_idx = dir_r ? (idx - stride) : (idx + stride);

  stepper_tick_gen #(
    .PER_W (PER_W)
  ) u_tick (
    .new_clk (new_clk),
    .rst     (rst),
    .en      (state == ST_RUN),
    .clear   (accept),
    .period  (period_r),
    .tick    (tick)
  );

  // Sequencer FSM with registered coil drive, status pulses and position.
  always_ff @(posedge new_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      dir_r     <= 1'b0;
      half_r    <= 1'b0;
      period_r  <= PER_W'(1);
      remaining <= '0;
      phase     <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      position  <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx       <= cmd_idx;
            phase     <= phase_of(cmd_idx);
            dir_r     <= cmd.cmd_dir;
            half_r    <= mode_is_half(cmd.cmd_mode);
            period_r  <= (cmd.period == '0) ? PER_W'(1) : cmd.period;
            remaining <= cmd.cmd_steps;
            if (cmd.cmd_steps == '0) begin
              // Empty move: acknowledge without ever entering RUN.
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end else begin
            phase <= hold_en ? phase_of(idx) : 4'b0000;
          end
        end

        ST_RUN: begin
          if (abort) begin
            // Abort wins over a coinciding tick: no step on this edge.
            state   <= ST_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (tick) begin
            idx       <= step_idx;
            phase     <= phase_of(step_idx);
            position  <= dir_r ? (position - POS_W'(1))
                               : (position + POS_W'(1));
            remaining <= remaining - STEP_W'(1);
            if (remaining == STEP_W'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Bench for stepper_seq_ctrl: directed scenarios plus randomized moves,
// each checked cycle by cycle against an arithmetic model of the move.
module tb_stepper_seq_ctrl;
  import stepper_pkg::*;

  localparam int STEP_W = 16;
  localparam int POS_W  = 24;
  localparam int PER_W  = 16;

  // ---------------- clock / reset ----------------
  logic new_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 new_clk = ~new_clk;

  logic                    hold_en;
  logic                    abort;
  logic [3:0]              phase;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic signed [POS_W-1:0] position;
  state_t                  dbg_state;

  stepper_seq_ctrl_if #(.STEP_W(STEP_W), .PER_W(PER_W)) cmd_if ();

  stepper_seq_ctrl #(
    .STEP_W (STEP_W),
    .POS_W  (POS_W),
    .PER_W  (PER_W)
  ) dut (
    .new_clk   (new_clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .hold_en   (hold_en),
    .abort     (abort),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .position  (position),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model state ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] tbl [8];
  int         midx = 0;   // coil table index the DUT should hold
  int         mpos = 0;   // signed position the DUT should hold

  // ---------------- driver / checker for one move ----------------
  // Expected behaviour at sample k (negedge after the k-th edge past the
  // accept edge): steps fired = floor(k/P), capped at N, frozen at the
  // abort edge (a step due on that edge is dropped).
  task automatic run_move(input bit dir, input int steps, input bit [1:0] mode,
                          input int per, input bit hold, input int abort_at,
                          input bit keep_valid, input bit skip_idle);
    int p, stride, aligned, endk, tail, fired, eidx, sgn;
    bit running, e_done, e_ab, e_rdy;
    logic [3:0]       e_ph;
    logic [POS_W-1:0] e_pos;
    hold_en = hold;
    if (!skip_idle) begin
      @(negedge new_clk);
      @(negedge new_clk);
      vectors++;
      if (phase !== (hold ? tbl[midx] : 4'b0000))
        $display("FAIL idle_phase got %b exp %b", phase, hold ? tbl[midx] : 4'b0000);
    end
    vectors++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept got %b exp 1", cmd_if.cmd_ready);
    end
    if (!skip_idle && phase !== (hold ? tbl[midx] : 4'b0000)) miscompares++;

    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_steps = STEP_W'(steps);
    cmd_if.cmd_mode  = mode;
    cmd_if.period    = PER_W'(per);
    cmd_if.cmd_valid = 1'b1;

    p       = (per == 0) ? 1 : per;
    stride  = mode[1] ? 1 : 2;
    aligned = (mode == 2'd0) ? (midx & 6) : (mode == 2'd1) ? (midx | 1) : midx;
    sgn     = dir ? -1 : 1;
    endk    = (abort_at > 0) ? abort_at : steps * p;
    tail    = keep_valid ? 0 : 2;
    fired   = 0;
    eidx    = aligned;

    for (int k = 0; k <= endk + tail; k++) begin
      @(negedge new_clk);
      fired = (abort_at > 0 && k >= abort_at) ? (abort_at - 1) / p : k / p;
      if (fired > steps) fired = steps;
      running = (abort_at > 0) ? (k < abort_at) : (fired < steps);
      eidx    = (((aligned + sgn * stride * fired) % 8) + 8) % 8;
      e_ph    = (k <= endk || hold) ? tbl[eidx] : 4'b0000;
      e_pos   = POS_W'(mpos + sgn * fired);
      e_done  = (abort_at == 0) && (k == steps * p);
      e_ab    = (abort_at > 0) && (k == abort_at);
      e_rdy   = !running && !abort;

      vectors++;
      if (phase !== e_ph) begin
        miscompares++;
        $display("FAIL phase k=%0d got %b exp %b", k, phase, e_ph);
      end
      vectors++;
      if (busy !== running) begin
        miscompares++;
        $display("FAIL busy k=%0d got %b exp %b", k, busy, running);
      end
      vectors++;
      if (done !== e_done) begin
        miscompares++;
        $display("FAIL done k=%0d got %b exp %b", k, done, e_done);
      end
      vectors++;
      if (aborted !== e_ab) begin
        miscompares++;
        $display("FAIL aborted k=%0d got %b exp %b", k, aborted, e_ab);
      end
      vectors++;
      if (position !== e_pos) begin
        miscompares++;
        $display("FAIL position k=%0d got %0d exp %0d", k, position, $signed(e_pos));
      end
      vectors++;
      if (cmd_if.cmd_ready !== e_rdy) begin
        miscompares++;
        $display("FAIL cmd_ready k=%0d got %b exp %b", k, cmd_if.cmd_ready, e_rdy);
      end

      // Drive for the next edge.
      if (k == 0 && !keep_valid) cmd_if.cmd_valid = 1'b0;
      if (k < endk) begin
        // Command fields wander during the move; they must not matter.
        cmd_if.cmd_mode  = 2'($urandom_range(0, 3));
        cmd_if.period    = PER_W'($urandom_range(0, 9));
        cmd_if.cmd_steps = STEP_W'($urandom_range(0, 9));
        cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
      end
      if (abort_at > 0 && k == abort_at - 1) abort = 1'b1;
      if (abort_at > 0 && k == abort_at)     abort = 1'b0;
    end
    midx = eidx;
    mpos = mpos + sgn * fired;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge new_clk);
    vectors++;
    if (phase !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got phase=%b busy=%b done=%b aborted=%b exp 0000/0/0/0",
               phase, busy, done, aborted);
    end
    vectors++;
    if (position !== '0 || cmd_if.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pos_ready got pos=%0d ready=%b exp 0/0", position, cmd_if.cmd_ready);
    end
    rst = 1'b0;
    @(negedge new_clk);
    vectors++;
    if (cmd_if.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL post_reset got ready=%b state=%0d exp 1/IDLE", cmd_if.cmd_ready, dbg_state);
    end
    midx = 0;
    mpos = 0;
  endtask

  task automatic test_half_fwd();
    run_move(1'b0, 8, 2'd2, 3, 1'b1, 0, 1'b0, 1'b0);
    vectors++;
    if (position !== POS_W'(8)) begin
      miscompares++;
      $display("FAIL half_fwd_position got %0d exp 8", position);
    end
  endtask

  task automatic test_wave_rev();
    // Walk to index 3 with half steps, then the wave reverse move.
    run_move(1'b0, (3 - midx + 8) % 8, 2'd2, 1, 1'b1, 0, 1'b0, 1'b0);
    run_move(1'b1, 4, 2'd0, 1, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full_period0();
    run_move(1'b0, 4, 2'd1, 0, 1'b1, 0, 1'b0, 1'b0);
    run_move(1'b0, 3, 2'd3, 0, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_move(1'b0, 100, 2'd1, 5, 1'b1, 12, 1'b0, 1'b0);
    // Abort landing exactly on a step edge drops that step.
    run_move(1'b1, 20, 2'd2, 5, 1'b1, 10, 1'b0, 1'b0);
  endtask

  task automatic test_zero_steps();
    run_move(1'b0, 0, 2'd2, 3, 1'b1, 0, 1'b0, 1'b0);
    run_move(1'b1, 0, 2'd1, 0, 1'b0, 0, 1'b0, 1'b0);
    // Abort in IDLE blocks acceptance but does nothing else.
    @(negedge new_clk);
    hold_en          = 1'b1;
    abort            = 1'b1;
    cmd_if.cmd_steps = STEP_W'(5);
    cmd_if.cmd_valid = 1'b1;
    #1;
    vectors++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_abort_ready got %b exp 0", cmd_if.cmd_ready);
    end
    @(negedge new_clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_abort_effect got busy=%b done=%b aborted=%b exp 0/0/0",
               busy, done, aborted);
    end
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_hold_off();
    run_move(1'b0, 2, 2'd1, 1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // cmd_valid stays high through RUN; the next command goes in right
    // after the done edge.
    run_move(1'b0, 3, 2'd1, 2, 1'b1, 0, 1'b1, 1'b0);
    run_move(1'b1, 2, 2'd2, 1, 1'b1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int st, pe, ab;
    bit [1:0] md;
    for (int i = 0; i < 14; i++) begin
      st = $urandom_range(0, 6);
      pe = $urandom_range(0, 4);
      md = 2'($urandom_range(0, 3));
      ab = 0;
      if (st * ((pe == 0) ? 1 : pe) >= 2 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, st * ((pe == 0) ? 1 : pe) - 1);
      run_move(1'($urandom_range(0, 1)), st, md, pe, 1'($urandom_range(0, 1)),
               ab, 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge new_clk);
    hold_en          = 1'b1;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = STEP_W'(50);
    cmd_if.cmd_mode  = 2'd2;
    cmd_if.period    = PER_W'(2);
    cmd_if.cmd_valid = 1'b1;
    @(negedge new_clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (7) @(negedge new_clk);
    vectors++;
    if (busy !== 1'b1 || position === '0) begin
      miscompares++;
      $display("FAIL pre_reset_move got busy=%b pos=%0d exp 1/nonzero", busy, position);
    end
    @(posedge new_clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (phase !== 4'b0000 || position !== '0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got phase=%b pos=%0d busy=%b ready=%b exp 0000/0/0/0",
               phase, position, busy, cmd_if.cmd_ready);
    end
    @(negedge new_clk);
    rst  = 1'b0;
    midx = 0;
    mpos = 0;
    run_move(1'b1, 3, 2'd0, 2, 1'b1, 0, 1'b0, 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
            4'b0100, 4'b1100, 4'b1000, 4'b1001};
    hold_en          = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = '0;
    cmd_if.cmd_mode  = 2'd0;
    cmd_if.period    = '0;

    test_reset();
    test_half_fwd();
    test_wave_rev();
    test_full_period0();
    test_abort();
    test_zero_steps();
    test_hold_off();
    test_back_to_back();
    test_random();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
